// File: rtl/demux_lane_deserializer.sv
// Deserializes the four demux lanes into DATA_W-bit words, one hold slot per lane,
// and hands them out round-robin on a valid/ready port. Flags stray lane activity.
module demux_lane_deserializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_vld,
  input  logic [1:0]        lane_sel,
  input  logic [3:0]        lane_y,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              ovf,
  output logic              err
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [DATA_W-2:0] sh   [LANES];
  logic [CNT_W-1:0]  cnt  [LANES];
  logic [DATA_W-1:0] hold [LANES];
  logic [LANES-1:0]  hold_full;
  logic [1:0]        rr;
  logic [0:0]        state, state_nx;

  logic              load_c;
  logic              grant_vld_c;
  logic [1:0]        grant_c;
  logic              bit_c;
  logic [DATA_W-1:0] word_c;
  logic              done_c;
  logic              drop_c;
  logic              stray_c;

  assign bit_c   = lane_y[lane_sel];
  assign word_c  = {bit_c, sh[lane_sel]};
  assign done_c  = bit_vld && (cnt[lane_sel] == CNT_LAST);
  // A drain of the same lane on this edge frees the slot for the completing word
  assign drop_c  = done_c && hold_full[lane_sel] && !(load_c && (grant_c == lane_sel));
  assign stray_c = |(lane_y & ~(4'b0001 << lane_sel));

  // Round-robin pick: first full slot after rr, rr itself last
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = rr;
    for (int k = LANES; k >= 1; k--) begin
      if (hold_full[2'(rr + 2'(k))]) begin
        grant_vld_c = 1'b1;
        grant_c     = 2'(rr + 2'(k));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld_c) begin
          load_c   = 1'b1;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (out_rdy) begin
          if (grant_vld_c) begin
            load_c = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output register and arbiter pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_lane <= 2'd0;
      rr       <= 2'd3;
    end else begin
      out_vld <= (state_nx == PRESENT);
      if (load_c) begin
        out_data <= hold[grant_c];
        out_lane <= grant_c;
        rr       <= grant_c;
      end
    end
  end

  // Per-lane capture, hold slots and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        sh[i]   <= '0;
        cnt[i]  <= '0;
        hold[i] <= '0;
      end
      hold_full <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      ovf <= drop_c;
      if (bit_vld && stray_c) begin
        err <= 1'b1;
      end
      if (load_c) begin
        hold_full[grant_c] <= 1'b0;
      end
      if (bit_vld) begin
        sh[lane_sel]  <= word_c[DATA_W-1:1];
        cnt[lane_sel] <= done_c ? '0 : cnt[lane_sel] + CNT_W'(1);
        if (done_c && !drop_c) begin
          hold[lane_sel]      <= word_c;
          hold_full[lane_sel] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed plus randomized checks of demux_lane_deserializer against a
// word-level reference model of lane assembly, hold slots and round-robin output.
module tb_demux_lane_deserializer;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_vld = 1'b0;
  logic [1:0]    lane_sel = 2'd0;
  logic [3:0]    lane_y = 4'd0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          ovf;
  logic          err;

  demux_lane_deserializer #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bit_vld(bit_vld), .lane_sel(lane_sel), .lane_y(lane_y),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_lane(out_lane),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            m_cnt [4];
  logic [DW-1:0] m_acc [4];
  logic [DW-1:0] m_hold [4];
  bit            m_hf [4];
  bit            m_vld, m_ovf, m_err;
  logic [DW-1:0] m_data;
  int            m_lane, m_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_acc[i] = '0; m_hold[i] = '0; m_hf[i] = 0;
    end
    m_vld = 0; m_ovf = 0; m_err = 0; m_data = '0; m_lane = 0; m_rr = 3;
  endtask

  task automatic model_step(input logic bv, input logic [1:0] sel, input logic [3:0] y,
                            input logic rdy);
    bit take;
    int g;
    int l;
    take = 0; g = 0;
    if (!m_vld || rdy) begin
      for (int k = 1; k <= 4; k++) begin
        l = (m_rr + k) % 4;
        if (!take && m_hf[l]) begin take = 1; g = l; end
      end
      if (take) begin
        m_vld = 1; m_data = m_hold[g]; m_lane = g; m_rr = g; m_hf[g] = 0;
      end else begin
        m_vld = 0;
      end
    end
    m_ovf = 0;
    if (bv) begin
      l = int'(sel);
      for (int i = 0; i < 4; i++) if (i != l && y[i]) m_err = 1;
      m_acc[l] = m_acc[l] | (DW'(y[l]) << m_cnt[l]);
      m_cnt[l] = m_cnt[l] + 1;
      if (m_cnt[l] == DW) begin
        if (m_hf[l]) m_ovf = 1;
        else begin m_hold[l] = m_acc[l]; m_hf[l] = 1; end
        m_acc[l] = '0;
        m_cnt[l] = 0;
      end
    end
  endtask

  task automatic check_all();
    check("out_vld", 32'(out_vld), 32'(m_vld));
    if (m_vld) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_lane", 32'(out_lane), 32'(m_lane));
    end
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic bv, input logic [1:0] sel, input logic [3:0] y,
                      input logic rdy);
    bit_vld = bv; lane_sel = sel; lane_y = y; out_rdy = rdy;
    @(posedge clk);
    model_step(bv, sel, y, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bit_vld = 0; out_rdy = 0; lane_y = '0;
    rst = 1;
    #1;
    model_reset();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_lane", 32'(out_lane), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic send_word(input logic [1:0] lane, input logic [DW-1:0] w, input logic rdy);
    for (int i = 0; i < DW; i++) step(1'b1, lane, 4'(w[i]) << lane, rdy);
  endtask

  logic          tbits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [DW-1:0] w1, w2, w3, w4, w0;
  int            lanes_seen [5];

  initial begin
    #2;
    // Lane 0 known word
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, {3'b000, tbits[i]}, 1'b0);
    check("t1_vld_at_T", 32'(out_vld), 32'd0);
    step(1'b0, 2'd0, 4'd0, 1'b0);
    check("t1_vld", 32'(out_vld), 32'd1);
    check("t1_data", 32'(out_data), 32'h4D);
    check("t1_lane", 32'(out_lane), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1);

    // Interleaved lanes 1 and 2, back-to-back output
    w1 = DW'($urandom); w2 = DW'($urandom);
    for (int i = 0; i < DW; i++) begin
      step(1'b1, 2'd1, {2'b00, w1[i], 1'b0}, 1'b1);
      step(1'b1, 2'd2, {1'b0, w2[i], 2'b00}, 1'b1);
    end
    check("t2_first_lane", 32'(out_lane), 32'd1);
    check("t2_first_data", 32'(out_data), 32'(w1));
    step(1'b0, 2'd0, 4'd0, 1'b1);
    check("t2_second_vld", 32'(out_vld), 32'd1);
    check("t2_second_lane", 32'(out_lane), 32'd2);
    check("t2_second_data", 32'(out_data), 32'(w2));
    step(1'b0, 2'd0, 4'd0, 1'b1);

    // Stalled consumer: lane 3 overflows while a lane 0 word is presented
    w0 = DW'($urandom); w3 = DW'($urandom); w4 = DW'($urandom);
    send_word(2'd0, w0, 1'b0);
    send_word(2'd3, w3, 1'b0);
    send_word(2'd3, w4, 1'b0);
    check("t3_ovf", 32'(ovf), 32'd1);
    check("t3_data_stable", 32'(out_data), 32'(w0));
    step(1'b0, 2'd0, 4'd0, 1'b0);
    check("t3_ovf_pulse", 32'(ovf), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 4'd0, 1'b1);

    // All four slots full behind a presented lane 3 word
    do_reset();
    send_word(2'd3, DW'($urandom), 1'b0);
    for (int l = 0; l < 4; l++) send_word(2'(l), DW'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      lanes_seen[i] = int'(out_lane);
      step(1'b0, 2'd0, 4'd0, 1'b1);
    end
    check("t4_order0", 32'(lanes_seen[0]), 32'd3);
    check("t4_order1", 32'(lanes_seen[1]), 32'd0);
    check("t4_order2", 32'(lanes_seen[2]), 32'd1);
    check("t4_order3", 32'(lanes_seen[3]), 32'd2);
    check("t4_order4", 32'(lanes_seen[4]), 32'd3);

    // Stray lane sets sticky err
    do_reset();
    step(1'b1, 2'd1, 4'b0110, 1'b1);
    check("t5_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 4'b0000, 1'b1);
    check("t5_err_sticky", 32'(err), 32'd1);

    // Reset mid-word discards partial bits
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 4'($urandom_range(0, 1)), 1'b1);
    do_reset();
    send_word(2'd0, 8'hA5, 1'b1);
    step(1'b0, 2'd0, 4'd0, 1'b1);
    check("t6_vld", 32'(out_vld), 32'd1);
    check("t6_data", 32'(out_data), 32'hA5);
    step(1'b0, 2'd0, 4'd0, 1'b1);
    check("t6_single", 32'(out_vld), 32'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [1:0] s;
      logic [3:0] y;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) y = 4'($urandom);
      else y = 4'($urandom_range(0, 1)) << s;
      step(1'($urandom_range(0, 3) != 0), s, y, 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
